// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Holds the arbiter FSM encoding, the default byte width and the watchdog counter width.
package uart_tx_arbiter_pkg;

  localparam int UART_DATA_W = 8;
  localparam int TMO_CNT_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XREQ = 2'd1,
    ST_XREL = 2'd2,
    ST_CACK = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requester after 'last',
// wrapping from NUM_REQ-1 back to 0.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int GNT_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GNT_W-1:0]   last,
  output logic               any,
  output logic [GNT_W-1:0]   idx
);

  int cand;

  // Scanning offsets 1..NUM_REQ makes 'last' itself the lowest priority.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last) + k) % NUM_REQ;
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = GNT_W'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ four-phase clients.
// Optional transmitter-ack watchdog with sticky TIMEOUT_ERR: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = UART_DATA_W,
  parameter int GNT_W   = 2
`ifdef UART_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic [NUM_REQ-1:0]        CLI_REQ,
  input  logic [NUM_REQ*DATA_W-1:0] CLI_DATA,
  output logic [NUM_REQ-1:0]        CLI_ACK,
  output logic                      XMIT_REQ,
  output logic [DATA_W-1:0]         XMIT_DATA,
  input  logic                      XMIT_ACK,
  output logic [GNT_W-1:0]          GRANT,
  output logic                      BUSY
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic                      TIMEOUT_ERR
`endif
);

  arb_state_e          state_q, state_d;
  logic [GNT_W-1:0]    grant_q, grant_d;
  logic [GNT_W-1:0]    last_q, last_d;
  logic [DATA_W-1:0]   xmit_data_q, xmit_data_d;
  logic                xmit_req_q, xmit_req_d;
  logic [NUM_REQ-1:0]  cli_ack_q, cli_ack_d;
  logic [NUM_REQ-1:0]  grant_onehot;
  logic                pick_any;
  logic [GNT_W-1:0]    pick_idx;

`ifdef UART_ARB_TIMEOUT_EN
  logic [TMO_CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic                 tmo_err_q, tmo_err_d;
  logic                 tmo_hit;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GNT_W   (GNT_W)
  ) u_rr_pick (
    .req  (CLI_REQ),
    .last (last_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_d       = last_q;
    xmit_data_d  = xmit_data_q;
    xmit_req_d   = xmit_req_q;
    cli_ack_d    = cli_ack_q;
    grant_onehot = '0;
    grant_onehot[grant_q] = 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    tmo_err_d = tmo_err_q;
    tmo_hit   = (tmo_cnt_q == TMO_CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d     = pick_idx;
          xmit_data_d = CLI_DATA[int'(pick_idx)*DATA_W +: DATA_W];
          xmit_req_d  = 1'b1;
          state_d     = ST_XREQ;
`ifdef UART_ARB_TIMEOUT_EN
          tmo_cnt_d   = '0;
`endif
        end
      end
      ST_XREQ: begin
        if (XMIT_ACK) begin
          xmit_req_d = 1'b0;
          state_d    = ST_XREL;
        end
      end
      ST_XREL: begin
        if (!XMIT_ACK) begin
          cli_ack_d = grant_onehot;
          state_d   = ST_CACK;
        end
      end
      ST_CACK: begin
        // A client that already dropped REQ gets a single-cycle ACK here.
        if (!CLI_REQ[grant_q]) begin
          cli_ack_d = '0;
          last_d    = grant_q;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef UART_ARB_TIMEOUT_EN
    // Watchdog overrides the transmitter handshake and releases the client.
    if (state_q == ST_XREQ || state_q == ST_XREL) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
      if (tmo_hit) begin
        xmit_req_d = 1'b0;
        tmo_err_d  = 1'b1;
        cli_ack_d  = grant_onehot;
        state_d    = ST_CACK;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      last_q      <= GNT_W'(NUM_REQ - 1);
      xmit_data_q <= '0;
      xmit_req_q  <= 1'b0;
      cli_ack_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      xmit_data_q <= xmit_data_d;
      xmit_req_q  <= xmit_req_d;
      cli_ack_q   <= cli_ack_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign TIMEOUT_ERR = tmo_err_q;
`endif

  assign CLI_ACK   = cli_ack_q;
  assign XMIT_REQ  = xmit_req_q;
  assign XMIT_DATA = xmit_data_q;
  assign GRANT     = grant_q;
  assign BUSY      = (state_q != ST_IDLE);

endmodule
